seg7_scan_controller: RTL

Time-multiplexing controller for the four-digit seven-segment display. It sits upstream of the `Seven_Seg_Diff` digit decoder and drives that decoder's digit select, 5-bit symbol code and dot inputs. It scans the four digits at a programmable rate. It arbitrates between two sources: the live 4-digit score, and a one-shot 4-symbol message (e.g. "HELP", "LOSt") requested over a REQ/ACK handshake. Source switches and value snapshots happen only at frame boundaries, so the display never shows a torn frame.

---
 rtl/seg7_scan_controller.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/seg7_scan_controller.sv
// Four-digit seven-segment scan controller: multiplexes a live score and a
// REQ/ACK-latched message onto the Seven_Seg_Diff decoder inputs, switching only at frame boundaries.
module seg7_scan_controller #(
   parameter int REFRESH_DIV = 100000,
   parameter int MSG_HOLD    = 200,
   parameter bit LEAD_BLANK  = 1'b1
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic [15:0] SCORE_IN,
   input  logic [3:0]  DOTS_IN,
   input  logic        MSG_REQ,
   input  logic [19:0] MSG_IN,
   output logic        MSG_ACK,
   output logic        MSG_ACTIVE,
   output logic [1:0]  SEG_SELECT_OUT,
   output logic [4:0]  BIN_OUT,
   output logic        DOT_OUT,
   output logic        FRAME_TICK
);

   localparam int PW     = $clog2(REFRESH_DIV);
   localparam int HOLD_N = (MSG_HOLD < 1) ? 1 : MSG_HOLD;
   localparam int HW     = $clog2(HOLD_N + 1);
   localparam logic [PW-1:0] P_LAST    = PW'(REFRESH_DIV - 1);
   localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_N);
   localparam logic [4:0]    BLANK     = 5'h1F;

   typedef enum logic [0:0] {
      ST_SCORE = 1'b0,
      ST_MSG   = 1'b1
   } state_t;

   // Digit n is a leading zero when it and every more significant nibble is 0; digit 0 never is.
   function automatic logic lead_zero(input logic [15:0] s, input logic [1:0] n);
      logic z;
      z = (n != 2'd0);
      for (int k = 0; k < 4; k++) begin
         z = z & ((k < int'(n)) || (s[4*k +: 4] == 4'h0));
      end
      return z;
   endfunction

   logic [PW-1:0] r_pcnt;
   logic [1:0]    r_idx;
   state_t        r_state;
   logic [HW-1:0] r_hold;
   logic [15:0]   r_score;
   logic [3:0]    r_dots;
   logic [19:0]   r_msg;
   logic          r_ack;
   logic          r_active;
   logic          r_frame_tick;
   logic [1:0]    r_sel;
   logic [4:0]    r_bin;
   logic          r_dot;

   logic          w_tc;
   logic          w_wrap;
   logic [1:0]    w_idx_nxt;
   state_t        w_state_nxt;
   logic [HW-1:0] w_hold_nxt;
   logic [15:0]   w_score_nxt;
   logic [3:0]    w_dots_nxt;
   logic [19:0]   w_msg_nxt;
   logic          w_accept;
   logic [3:0]    w_nib;
   logic [4:0]    w_code;
   logic [4:0]    w_bin_nxt;
   logic          w_dot_nxt;

   assign w_tc      = (r_pcnt == P_LAST);
   assign w_wrap    = w_tc && (r_idx == 2'd3);
   assign w_idx_nxt = w_tc ? (r_idx + 2'd1) : r_idx;

   // Next-frame state, hold count and latched content; only a wrap edge changes anything.
   always_comb begin
      w_state_nxt = r_state;
      w_hold_nxt  = r_hold;
      w_score_nxt = r_score;
      w_dots_nxt  = r_dots;
      w_msg_nxt   = r_msg;
      w_accept    = 1'b0;
      if (w_wrap) begin
         case (r_state)
            ST_SCORE: begin
               w_score_nxt = SCORE_IN;
               w_dots_nxt  = DOTS_IN;
               if (MSG_REQ) begin
                  w_msg_nxt   = MSG_IN;
                  w_hold_nxt  = HOLD_LOAD;
                  w_state_nxt = ST_MSG;
                  w_accept    = 1'b1;
               end else begin
                  w_state_nxt = ST_SCORE;
               end
            end
            ST_MSG: begin
               if (r_hold > HW'(1)) begin
                  w_hold_nxt = r_hold - HW'(1);
               end else if (MSG_REQ) begin
                  w_msg_nxt  = MSG_IN;
                  w_hold_nxt = HOLD_LOAD;
                  w_accept   = 1'b1;
               end else begin
                  w_state_nxt = ST_SCORE;
                  w_hold_nxt  = HW'(0);
                  w_score_nxt = SCORE_IN;
                  w_dots_nxt  = DOTS_IN;
               end
            end
            default: begin
               w_state_nxt = ST_SCORE;
               w_hold_nxt  = HW'(0);
            end
         endcase
      end else begin
         w_accept = 1'b0;
      end
   end

   // Digit content for the index about to be shown, taken from the values being latched this edge.
   always_comb begin
      w_nib  = 4'h0;
      w_code = BLANK;
      case (w_idx_nxt)
         2'd0: begin w_nib = w_score_nxt[3:0];   w_code = w_msg_nxt[4:0];   end
         2'd1: begin w_nib = w_score_nxt[7:4];   w_code = w_msg_nxt[9:5];   end
         2'd2: begin w_nib = w_score_nxt[11:8];  w_code = w_msg_nxt[14:10]; end
         2'd3: begin w_nib = w_score_nxt[15:12]; w_code = w_msg_nxt[19:15]; end
         default: begin w_nib = 4'h0; w_code = BLANK; end
      endcase
      if (w_state_nxt == ST_MSG) begin
         w_bin_nxt = w_code;
         w_dot_nxt = 1'b0;
      end else begin
         w_bin_nxt = (LEAD_BLANK && lead_zero(w_score_nxt, w_idx_nxt)) ? BLANK : {1'b0, w_nib};
         w_dot_nxt = w_dots_nxt[w_idx_nxt];
      end
   end

   // Prescaler and digit index.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_pcnt <= '0;
         r_idx  <= 2'd0;
      end else if (w_tc) begin
         r_pcnt <= '0;
         r_idx  <= w_idx_nxt;
      end else begin
         r_pcnt <= r_pcnt + PW'(1);
      end
   end

   // Source-arbitration FSM with its snapshots and status pulses.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_state      <= ST_SCORE;
         r_hold       <= '0;
         r_score      <= 16'h0000;
         r_dots       <= 4'h0;
         r_msg        <= 20'h00000;
         r_ack        <= 1'b0;
         r_active     <= 1'b0;
         r_frame_tick <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_hold       <= w_hold_nxt;
         r_score      <= w_score_nxt;
         r_dots       <= w_dots_nxt;
         r_msg        <= w_msg_nxt;
         r_ack        <= w_accept;
         r_active     <= (w_state_nxt == ST_MSG);
         r_frame_tick <= w_wrap;
      end
   end

   // Decoder-facing outputs move together with the digit index.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_sel <= 2'd0;
         r_bin <= BLANK;
         r_dot <= 1'b0;
      end else if (w_tc) begin
         r_sel <= w_idx_nxt;
         r_bin <= w_bin_nxt;
         r_dot <= w_dot_nxt;
      end else begin
         r_sel <= r_sel;
         r_bin <= r_bin;
         r_dot <= r_dot;
      end
   end

   assign MSG_ACK        = r_ack;
   assign MSG_ACTIVE     = r_active;
   assign SEG_SELECT_OUT = r_sel;
   assign BIN_OUT        = r_bin;
   assign DOT_OUT        = r_dot;
   assign FRAME_TICK     = r_frame_tick;

endmodule
